column_buffer_ctrl: RTL and testbench

Parametrised multi-buffer column store between the Avalon-MM host writer and the pixel pipeline. The host streams per-column ray data as fixed-size beats. The block packs the beats into column words and fills a back buffer. Completed frames are presented to the display read port only at a frame boundary. It generalises the fixed 640-column, 28-bit, 2-beat, 3-buffer scheme with selectable double/triple buffering, writer back-pressure, abort and status readback.

---
 rtl/column_buffer_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_column_buffer_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/column_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : column_buffer_ctrl
// Purpose  : Multi-buffer column store. Packs Avalon write beats into column
//            words, fills a back buffer and presents completed frames to the
//            display read port at frame boundaries (double or triple buffered).
// Revision : 1.0 - initial release
// ============================================================================
module column_buffer_ctrl #(
    parameter int NUM_COLS      = 640,
    parameter int COL_BITS      = 28,
    parameter int BEAT_BITS     = 16,
    parameter int BEATS_PER_COL = 2,
    parameter int NUM_BUFS      = 3,
    parameter int COL_IDX_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chipselect,
    input  logic                 write,
    input  logic                 read,
    input  logic [1:0]           address,
    input  logic [BEAT_BITS-1:0] writedata,
    output logic [31:0]          readdata,
    output logic                 waitrequest,
    input  logic                 frame_start,
    input  logic [COL_IDX_W-1:0] rd_col,
    output logic [COL_BITS-1:0]  rd_data,
    output logic                 frame_swapped,
    output logic [7:0]           frames_dropped
);

    localparam int C_SR_W   = BEATS_PER_COL * BEAT_BITS;
    localparam int C_BEAT_W = (BEATS_PER_COL > 1) ? $clog2(BEATS_PER_COL) : 1;
    localparam int C_DEPTH  = NUM_BUFS * NUM_COLS;
    localparam int C_ADDR_W = $clog2(C_DEPTH);

    localparam logic [C_BEAT_W-1:0]  C_LAST_BEAT = C_BEAT_W'(BEATS_PER_COL - 1);
    localparam logic [COL_IDX_W-1:0] C_LAST_COL  = COL_IDX_W'(NUM_COLS - 1);
    localparam logic [1:0]           C_PEND_RST  = (NUM_BUFS == 3) ? 2'd2 : 2'd0;

    localparam logic [0:0] W_FILL = 1'b0;
    localparam logic [0:0] W_WAIT = 1'b1;

    logic [0:0]           r_state;
    logic [1:0]           r_rd_buf;
    logic [1:0]           r_wr_buf;
    logic [1:0]           r_pend_buf;
    logic                 r_pend_valid;
    logic                 r_shown_valid;
    logic [COL_IDX_W-1:0] r_wr_col;
    logic [C_BEAT_W-1:0]  r_beat;
    logic [C_SR_W-1:0]    r_shift;
    logic                 r_frame_swapped;
    logic [7:0]           r_frames_dropped;
    logic [COL_BITS-1:0]  r_rd_data;
    logic [COL_BITS-1:0]  r_mem [C_DEPTH];

    logic [C_SR_W+BEAT_BITS-1:0] w_cat;
    logic                        w_unused;
    logic [COL_BITS-1:0]         w_col_word;
    logic                        w_host_wr0;
    logic                        w_accept;
    logic                        w_last_beat;
    logic                        w_frame_done;
    logic                        w_ctrl_clear;
    logic                        w_swap;
    logic [C_ADDR_W-1:0]         w_wr_addr;
    logic [C_ADDR_W-1:0]         w_rd_addr;
    logic [31:0]                 w_status;

    // Beat 0 ends up most significant; bits above the column word fall off.
    assign w_cat      = {r_shift, writedata};
    assign w_col_word = w_cat[COL_BITS-1:0];
    assign w_unused   = ^w_cat;

    assign w_host_wr0   = chipselect & write & (address == 2'd0);
    assign waitrequest  = w_host_wr0 & (r_state == W_WAIT);
    assign w_accept     = w_host_wr0 & ~waitrequest;
    assign w_last_beat  = w_accept & (r_beat == C_LAST_BEAT);
    assign w_frame_done = w_last_beat & (r_wr_col == C_LAST_COL);
    assign w_ctrl_clear = chipselect & write & (address == 2'd1) & writedata[0]
                          & (r_state == W_FILL);
    assign w_swap       = frame_start & r_pend_valid;

    // Buffers are laid out back to back in one flat store.
    assign w_wr_addr = C_ADDR_W'(r_wr_buf * NUM_COLS + r_wr_col);
    assign w_rd_addr = C_ADDR_W'(r_rd_buf * NUM_COLS + rd_col);

    // Status word assembly.
    always_comb begin
        w_status                  = '0;
        w_status[0]               = r_pend_valid;
        w_status[1]               = (r_state == W_WAIT);
        w_status[3:2]             = r_rd_buf;
        w_status[15:8]            = r_frames_dropped;
        w_status[16 +: COL_IDX_W] = r_wr_col;
    end

    assign readdata = (chipselect & read & (address == 2'd2)) ? w_status : 32'd0;

    // Column store write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_mem[w_wr_addr] <= w_col_word;
        end
    end

    // Display read port, blanked until a first frame has been shown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_shown_valid ? r_mem[w_rd_addr] : '0;
        end
    end

    // Beat packing, column counter and buffer rotation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= W_FILL;
            r_rd_buf         <= 2'd0;
            r_wr_buf         <= 2'd1;
            r_pend_buf       <= C_PEND_RST;
            r_pend_valid     <= 1'b0;
            r_shown_valid    <= 1'b0;
            r_wr_col         <= '0;
            r_beat           <= '0;
            r_shift          <= '0;
            r_frame_swapped  <= 1'b0;
            r_frames_dropped <= 8'd0;
        end else begin
            r_frame_swapped <= 1'b0;

            if (w_accept) begin
                r_shift <= w_cat[C_SR_W-1:0];
                if (r_beat == C_LAST_BEAT) begin
                    r_beat   <= '0;
                    r_wr_col <= (r_wr_col == C_LAST_COL) ? '0 : r_wr_col + 1'b1;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end else if (w_ctrl_clear) begin
                r_wr_col <= '0;
                r_beat   <= '0;
            end

            if (NUM_BUFS == 2) begin
                // Writer stalls while the finished frame waits for display.
                if (w_frame_done) begin
                    r_pend_valid <= 1'b1;
                    r_state      <= W_WAIT;
                end else if (w_swap) begin
                    r_rd_buf        <= r_wr_buf;
                    r_wr_buf        <= r_rd_buf;
                    r_pend_valid    <= 1'b0;
                    r_shown_valid   <= 1'b1;
                    r_frame_swapped <= 1'b1;
                    r_state         <= W_FILL;
                end
            end else begin
                if (w_swap) begin
                    r_rd_buf        <= r_pend_buf;
                    r_shown_valid   <= 1'b1;
                    r_frame_swapped <= 1'b1;
                end
                if (w_swap && w_frame_done) begin
                    // Old pending goes on screen, the completing frame takes
                    // its place and the freed display buffer becomes writable.
                    r_pend_buf   <= r_wr_buf;
                    r_wr_buf     <= r_rd_buf;
                    r_pend_valid <= 1'b1;
                end else if (w_swap) begin
                    r_pend_buf   <= r_rd_buf;
                    r_pend_valid <= 1'b0;
                end else if (w_frame_done) begin
                    r_pend_buf   <= r_wr_buf;
                    r_wr_buf     <= r_pend_buf;
                    r_pend_valid <= 1'b1;
                    if (r_pend_valid && (r_frames_dropped != 8'hFF)) begin
                        r_frames_dropped <= r_frames_dropped + 8'd1;
                    end
                end
            end
        end
    end

    assign rd_data        = r_rd_data;
    assign frame_swapped  = r_frame_swapped;
    assign frames_dropped = r_frames_dropped;

endmodule
`default_nettype wire

// File: tb/tb_column_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_buffer_ctrl
// Purpose  : Directed bench for column_buffer_ctrl; index 0 is a triple
//            buffered instance, index 1 a double buffered one (4 columns).
// Revision : 1.0 - initial release
// ============================================================================
module tb_column_buffer_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  cs, wr, rd, fstart;
    logic [1:0]  addr  [2];
    logic [15:0] wdata [2];
    logic [9:0]  rcol  [2];
    logic [31:0] rdata [2];
    logic [27:0] rdd   [2];
    logic [7:0]  drop  [2];
    logic [1:0]  waitreq, swapped;

    int tests = 0;
    int fails = 0;

    column_buffer_ctrl #(.NUM_COLS(4), .NUM_BUFS(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .chipselect(cs[0]), .write(wr[0]),
        .read(rd[0]), .address(addr[0]), .writedata(wdata[0]),
        .readdata(rdata[0]), .waitrequest(waitreq[0]),
        .frame_start(fstart[0]), .rd_col(rcol[0]), .rd_data(rdd[0]),
        .frame_swapped(swapped[0]), .frames_dropped(drop[0])
    );

    column_buffer_ctrl #(.NUM_COLS(4), .NUM_BUFS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .chipselect(cs[1]), .write(wr[1]),
        .read(rd[1]), .address(addr[1]), .writedata(wdata[1]),
        .readdata(rdata[1]), .waitrequest(waitreq[1]),
        .frame_start(fstart[1]), .rd_col(rcol[1]), .rd_data(rdd[1]),
        .frame_swapped(swapped[1]), .frames_dropped(drop[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] beat_val(input logic [3:0] tag, input int c, input int b);
        return (b == 0) ? {4'h0, tag, 4'h0, 4'(c)} : {4'hB, 4'h0, 4'hB, 4'(c)};
    endfunction

    function automatic logic [27:0] exp_word(input logic [3:0] tag, input int c);
        logic [31:0] full;
        full = {beat_val(tag, c, 0), beat_val(tag, c, 1)};
        return full[27:0];
    endfunction

    task automatic bus_wr(input int s, input logic [1:0] a, input logic [15:0] d, input bit fs);
        cs[s] = 1'b1; wr[s] = 1'b1; addr[s] = a; wdata[s] = d; fstart[s] = fs;
        tick();
        cs[s] = 1'b0; wr[s] = 1'b0; fstart[s] = 1'b0;
    endtask

    // Beats first..first+n-1 of a frame; optional frame_start on the last one.
    task automatic write_beats(input int s, input logic [3:0] tag, input int first,
                               input int n, input bit last_fs);
        for (int i = first; i < first + n; i++) begin
            bus_wr(s, 2'd0, beat_val(tag, i / 2, i % 2), last_fs && (i == first + n - 1));
        end
    endtask

    task automatic pulse_fs(input int s, input string tag);
        fstart[s] = 1'b1;
        tick();
        fstart[s] = 1'b0;
        chk({tag, "_swap1"}, {31'd0, swapped[s]}, 32'd1);
        tick();
        chk({tag, "_swap0"}, {31'd0, swapped[s]}, 32'd0);
    endtask

    task automatic chk_status(input int s, input string tag, input logic [31:0] exp);
        cs[s] = 1'b1; rd[s] = 1'b1; addr[s] = 2'd2;
        #1;
        chk(tag, rdata[s], exp);
        cs[s] = 1'b0; rd[s] = 1'b0;
        #1;
    endtask

    task automatic sweep(input int s, input string tag, input logic [3:0] ftag, input bit shown);
        for (int c = 0; c < 4; c++) begin
            rcol[s] = 10'(c);
            tick();
            chk(tag, {4'h0, rdd[s]}, shown ? {4'h0, exp_word(ftag, c)} : 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cs = '0; wr = '0; rd = '0; fstart = '0;
        for (int s = 0; s < 2; s++) begin
            addr[s] = 2'd0; wdata[s] = 16'd0; rcol[s] = 10'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", {4'h0, rdd[0]}, 32'd0);
        chk("rst_readdata", rdata[0], 32'd0);
        chk("rst_waitreq", {30'd0, waitreq}, 32'd0);
        chk("rst_swapped", {30'd0, swapped}, 32'd0);
        chk("rst_dropped", {24'd0, drop[0]}, 32'd0);
        chk_status(0, "rst_status", 32'h0);
        reset_n = 1'b1;
        tick();

        // Triple buffer: first frame, blank before swap, shown after.
        write_beats(0, 4'hA, 0, 8, 1'b0);
        chk_status(0, "t1_pending", 32'h1);
        chk("t1_no_swap", {31'd0, swapped[0]}, 32'd0);
        sweep(0, "t2_blank", 4'hA, 1'b0);
        pulse_fs(0, "t1");
        chk_status(0, "t1_status", 32'h4);
        sweep(0, "t1_read", 4'hA, 1'b1);

        // Two frames without frame_start: one drop, second frame shown.
        write_beats(0, 4'hB, 0, 8, 1'b0);
        write_beats(0, 4'hC, 0, 8, 1'b0);
        chk("t3_dropped", {24'd0, drop[0]}, 32'd1);
        chk_status(0, "t3_status", 32'h105);
        sweep(0, "t3_still_a", 4'hA, 1'b1);
        pulse_fs(0, "t3");
        chk_status(0, "t3_after", 32'h100);
        sweep(0, "t3_read_c", 4'hC, 1'b1);

        // frame_start coincident with the final beat while a frame is pending.
        write_beats(0, 4'hD, 0, 8, 1'b0);
        write_beats(0, 4'hE, 0, 8, 1'b1);
        chk("t5_swap", {31'd0, swapped[0]}, 32'd1);
        chk("t5_dropped", {24'd0, drop[0]}, 32'd1);
        chk_status(0, "t5_status", 32'h109);
        sweep(0, "t5_read_d", 4'hD, 1'b1);
        pulse_fs(0, "t5");
        sweep(0, "t5_read_e", 4'hE, 1'b1);
        chk_status(0, "t5_after", 32'h104);

        // Partial frame, address 3 ignored, control clear, clean refill.
        write_beats(0, 4'hF, 0, 5, 1'b0);
        chk_status(0, "t6_partial", 32'h20104);
        bus_wr(0, 2'd3, 16'h0001, 1'b0);
        chk_status(0, "t6_addr3", 32'h20104);
        bus_wr(0, 2'd1, 16'h0001, 1'b0);
        chk_status(0, "t6_cleared", 32'h104);
        write_beats(0, 4'h7, 0, 8, 1'b0);
        pulse_fs(0, "t6");
        sweep(0, "t6_read", 4'h7, 1'b1);

        // Double buffer: stall after a full frame until frame_start.
        write_beats(1, 4'h2, 0, 8, 1'b0);
        chk_status(1, "t4_wait_status", 32'h3);
        cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 2'd2;
        #1;
        chk("t4_read_no_stall", {31'd0, waitreq[1]}, 32'd0);
        cs[1] = 1'b0; rd[1] = 1'b0;
        cs[1] = 1'b1; wr[1] = 1'b1; addr[1] = 2'd0; wdata[1] = beat_val(4'h3, 0, 0);
        #1;
        chk("t4_stall0", {31'd0, waitreq[1]}, 32'd1);
        tick();
        tick();
        chk("t4_stall2", {31'd0, waitreq[1]}, 32'd1);
        fstart[1] = 1'b1;
        tick();
        fstart[1] = 1'b0;
        chk("t4_swap", {31'd0, swapped[1]}, 32'd1);
        chk("t4_released", {31'd0, waitreq[1]}, 32'd0);
        tick();
        cs[1] = 1'b0; wr[1] = 1'b0;
        chk_status(1, "t4_fill", 32'h4);
        write_beats(1, 4'h3, 1, 1, 1'b0);
        chk_status(1, "t4_col1", 32'h10004);
        sweep(1, "t4_read_2", 4'h2, 1'b1);
        write_beats(1, 4'h3, 2, 6, 1'b0);
        chk_status(1, "t4_wait2", 32'h7);
        pulse_fs(1, "t4");
        chk_status(1, "t4_after", 32'h0);
        sweep(1, "t4_read_3", 4'h3, 1'b1);

        // Reset in the middle of column 2 (beat 1 pending).
        write_beats(0, 4'hF, 0, 5, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t2_rst_rd_data", {4'h0, rdd[0]}, 32'd0);
        chk("t2_rst_waitreq", {31'd0, waitreq[0]}, 32'd0);
        chk("t2_rst_swapped", {31'd0, swapped[0]}, 32'd0);
        chk("t2_rst_dropped", {24'd0, drop[0]}, 32'd0);
        chk_status(0, "t2_rst_status", 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        sweep(0, "t2_rst_blank", 4'h9, 1'b0);
        write_beats(0, 4'h9, 0, 8, 1'b0);
        pulse_fs(0, "t2");
        chk_status(0, "t2_status", 32'h4);
        sweep(0, "t2_read", 4'h9, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
